// File: rtl/arf_access_sequencer_if.sv
// rtl/arf_access_sequencer_if.sv - request/response handshake between control unit and ARF access sequencer

interface arf_access_sequencer_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] wr_data;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;

  // Control unit side: issues requests, receives completions
  modport master (
    output req_valid,
    output req_op,
    output wr_data,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  // Sequencer side
  modport slave (
    input  req_valid,
    input  req_op,
    input  wr_data,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/arf_access_sequencer.sv
// rtl/arf_access_sequencer.sv - sequences 16-bit word transfers through the address register file and byte memory

module arf_access_sequencer #(
  parameter bit RESTORE_AR = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  arf_access_sequencer_if.slave req_if,
  output logic [2:0]            arf_funsel_o,
  output logic [2:0]            arf_regsel_o,
  output logic [1:0]            arf_outdsel_o,
  input  logic [15:0]           arf_outd_i,
  input  logic [7:0]            mem_data_i,
  output logic [7:0]            mem_data_o,
  output logic                  mem_cs_o,
  output logic                  mem_wr_o
);

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F0   = 4'd1;
  localparam logic [3:0] S_F1   = 4'd2;
  localparam logic [3:0] S_A0   = 4'd3;
  localparam logic [3:0] S_A1   = 4'd4;
  localparam logic [3:0] S_P0   = 4'd5;
  localparam logic [3:0] S_P1   = 4'd6;
  localparam logic [3:0] S_P2   = 4'd7;
  localparam logic [3:0] S_R0   = 4'd8;
  localparam logic [3:0] S_R1   = 4'd9;
  localparam logic [3:0] S_DONE = 4'd10;

  // ARF function codes and active-low register enables
  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] SEL_NONE = 3'b111;
  localparam logic [2:0] SEL_PC   = 3'b011;
  localparam logic [2:0] SEL_AR   = 3'b101;
  localparam logic [2:0] SEL_SP   = 3'b110;

  localparam logic [1:0] OUT_PC = 2'b00;
  localparam logic [1:0] OUT_AR = 2'b10;
  localparam logic [1:0] OUT_SP = 2'b11;

  logic [3:0]  state_q, state_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        accept;

  // The address from the ARF feeds the memory directly; the sequencer never decodes it.
  logic unused_outd;
  assign unused_outd = ^arf_outd_i;

  assign accept = req_if.req_valid && (state_q == S_IDLE);

  assign req_if.req_ready  = (state_q == S_IDLE);
  assign req_if.resp_valid = (state_q == S_DONE) && !rst_i;
  assign req_if.resp_data  = resp_data_q;

  // Next-state selection: each op walks a fixed chain of states into DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          case (req_if.req_op)
            OP_FETCH: state_d = S_F0;
            OP_LOAD:  state_d = S_A0;
            OP_PUSH:  state_d = S_P0;
            OP_POP:   state_d = S_R0;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_DONE;
      S_A0:    state_d = S_A1;
      S_A1:    state_d = S_DONE;
      S_P0:    state_d = S_P1;
      S_P1:    state_d = S_P2;
      S_P2:    state_d = S_DONE;
      S_R0:    state_d = S_R1;
      S_R1:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Data path: capture push data at acceptance, assemble read bytes little-endian
  always_comb begin
    wr_data_d   = accept ? req_if.wr_data : wr_data_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_F0, S_A0, S_R0: resp_data_d = {resp_data_q[15:8], mem_data_i};
      S_F1, S_A1, S_R1: resp_data_d = {mem_data_i, resp_data_q[7:0]};
      default:          resp_data_d = resp_data_q;
    endcase
  end

  // ARF and memory controls decoded from state; reset forces the idle pattern so an
  // aborted operation makes no further register or memory update at the reset edge
  always_comb begin
    arf_funsel_o  = FUN_DEC;
    arf_regsel_o  = SEL_NONE;
    arf_outdsel_o = OUT_PC;
    mem_cs_o      = 1'b1;
    mem_wr_o      = 1'b0;
    mem_data_o    = 8'h00;
    if (!rst_i) begin
      case (state_q)
        S_F0, S_F1: begin
          arf_outdsel_o = OUT_PC;
          mem_cs_o      = 1'b0;
          arf_funsel_o  = FUN_INC;
          arf_regsel_o  = SEL_PC;
        end
        S_A0: begin
          arf_outdsel_o = OUT_AR;
          mem_cs_o      = 1'b0;
          arf_funsel_o  = FUN_INC;
          arf_regsel_o  = SEL_AR;
        end
        S_A1: begin
          arf_outdsel_o = OUT_AR;
          mem_cs_o      = 1'b0;
          // Step AR back so the op leaves it pointing at the word's low byte
          if (RESTORE_AR) begin
            arf_funsel_o = FUN_DEC;
            arf_regsel_o = SEL_AR;
          end
        end
        S_P0: begin
          arf_funsel_o = FUN_DEC;
          arf_regsel_o = SEL_SP;
        end
        S_P1: begin
          arf_outdsel_o = OUT_SP;
          mem_cs_o      = 1'b0;
          mem_wr_o      = 1'b1;
          mem_data_o    = wr_data_q[15:8];
          arf_funsel_o  = FUN_DEC;
          arf_regsel_o  = SEL_SP;
        end
        S_P2: begin
          arf_outdsel_o = OUT_SP;
          mem_cs_o      = 1'b0;
          mem_wr_o      = 1'b1;
          mem_data_o    = wr_data_q[7:0];
        end
        S_R0, S_R1: begin
          arf_outdsel_o = OUT_SP;
          mem_cs_o      = 1'b0;
          arf_funsel_o  = FUN_INC;
          arf_regsel_o  = SEL_SP;
        end
        default: begin
          arf_regsel_o = SEL_NONE;
        end
      endcase
    end
  end

  // State and data registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_data_q   <= 16'h0000;
      resp_data_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wr_data_q   <= wr_data_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_arf_access_sequencer.sv
// tb/tb_arf_access_sequencer.sv - directed scoreboard bench for arf_access_sequencer with ARF and memory models

module tb_arf_access_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  arf_access_sequencer_if if0 ();
  arf_access_sequencer_if if1 ();

  logic [2:0]  funsel0, regsel0, funsel1, regsel1;
  logic [1:0]  outdsel0, outdsel1;
  logic [15:0] outd0, outd1;
  logic [7:0]  din0, din1, dout0, dout1;
  logic        cs0, wr0, cs1, wr1;

  logic [15:0] pc, ar, sp, pc1, ar1, sp1;
  logic [7:0]  mem [0:65535];

  logic        load_en = 1'b0;
  logic [15:0] load_pc, load_ar, load_sp;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr;
  logic [7:0]  poke_data;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_word;
  int done_cyc;

  arf_access_sequencer #(.RESTORE_AR(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_if(if0),
    .arf_funsel_o(funsel0), .arf_regsel_o(regsel0), .arf_outdsel_o(outdsel0),
    .arf_outd_i(outd0), .mem_data_i(din0), .mem_data_o(dout0),
    .mem_cs_o(cs0), .mem_wr_o(wr0)
  );

  arf_access_sequencer #(.RESTORE_AR(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_if(if1),
    .arf_funsel_o(funsel1), .arf_regsel_o(regsel1), .arf_outdsel_o(outdsel1),
    .arf_outd_i(outd1), .mem_data_i(din1), .mem_data_o(dout1),
    .mem_cs_o(cs1), .mem_wr_o(wr1)
  );

  function automatic logic [15:0] step(input logic [15:0] v, input logic [2:0] fs);
    case (fs)
      3'b000:  return v - 16'd1;
      3'b001:  return v + 16'd1;
      default: return v;
    endcase
  endfunction

  assign outd0 = (outdsel0 == 2'b10) ? ar  : (outdsel0 == 2'b11) ? sp  : pc;
  assign outd1 = (outdsel1 == 2'b10) ? ar1 : (outdsel1 == 2'b11) ? sp1 : pc1;
  assign din0  = mem[outd0];
  assign din1  = mem[outd1];

  always @(posedge clk) begin
    if (load_en) begin
      pc <= load_pc;  ar <= load_ar;  sp <= load_sp;
      pc1 <= load_pc; ar1 <= load_ar; sp1 <= load_sp;
    end else begin
      if (!regsel0[2]) pc  <= step(pc,  funsel0);
      if (!regsel0[1]) ar  <= step(ar,  funsel0);
      if (!regsel0[0]) sp  <= step(sp,  funsel0);
      if (!regsel1[2]) pc1 <= step(pc1, funsel1);
      if (!regsel1[1]) ar1 <= step(ar1, funsel1);
      if (!regsel1[0]) sp1 <= step(sp1, funsel1);
    end
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (!cs0 && wr0) mem[outd0] <= dout0;
    else if (!cs1 && wr1) mem[outd1] <= dout1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_regs(input logic [15:0] p, input logic [15:0] a, input logic [15:0] s);
    load_pc = p; load_ar = a; load_sp = s; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_req(input bit u1, input logic [1:0] op, input logic [15:0] wd,
                        input logic [15:0] exp_word, input int exp_lat, input string tag);
    int n;
    int lat;
    logic [15:0] e;
    exp_q.push_back(exp_word);
    if (u1) begin
      if1.req_valid = 1'b1; if1.req_op = op; if1.wr_data = wd;
    end else begin
      if0.req_valid = 1'b1; if0.req_op = op; if0.wr_data = wd;
    end
    n = 0;
    while (!(u1 ? if1.req_ready : if0.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    lat = 1;
    if1.req_valid = 1'b0;
    if0.req_valid = 1'b0;
    while (!(u1 ? if1.resp_valid : if0.resp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    chk({tag, "_data"}, 32'(u1 ? if1.resp_data : if0.resp_data), 32'(e));
    done_cyc = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int not_ready;
    int pulses;
    logic [15:0] got;
    rst = 1'b1;
    if0.req_valid = 1'b0; if0.req_op = 2'b00; if0.wr_data = 16'h0000;
    if1.req_valid = 1'b0; if1.req_op = 2'b00; if1.wr_data = 16'h0000;
    load_pc = 16'h0; load_ar = 16'h0; load_sp = 16'h0;
    poke_addr = 16'h0; poke_data = 8'h0;
    got = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(if0.resp_valid), 32'd0);
    chk("rst_cs",         32'(cs0),            32'd1);
    chk("rst_wr",         32'(wr0),            32'd0);
    chk("rst_regsel",     32'(regsel0),        32'b111);
    chk("rst_funsel",     32'(funsel0),        32'b000);
    chk("rst_outdsel",    32'(outdsel0),       32'b00);
    chk("rst_dout",       32'(dout0),          32'h00);
    chk("rst_resp_data",  32'(if0.resp_data),  32'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(if0.req_ready), 32'd1);
    last_word = 16'h0000;

    // FETCH
    set_regs(16'h0010, 16'h0200, 16'h0100);
    poke(16'h0010, 8'h34);
    poke(16'h0011, 8'h12);
    do_req(1'b0, 2'b00, 16'h0000, 16'h1234, 3, "fetch");
    chk("fetch_pc", 32'(pc), 32'h0012);
    last_word = 16'h1234;

    // PUSH then back-to-back POP
    do_req(1'b0, 2'b10, 16'hBEEF, last_word, 4, "push");
    chk("push_m_ff", 32'(mem[16'h00FF]), 32'h00BE);
    chk("push_m_fe", 32'(mem[16'h00FE]), 32'h00EF);
    chk("push_sp",   32'(sp),            32'h00FE);
    p = done_cyc;
    do_req(1'b0, 2'b11, 16'h0000, 16'hBEEF, 3, "pop");
    chk("pop_sp", 32'(sp), 32'h0100);
    chk("b2b_gap", 32'(done_cyc - p), 32'd4);
    last_word = 16'hBEEF;

    // LOAD_AR with and without restore
    poke(16'h0200, 8'hCD);
    poke(16'h0201, 8'hAB);
    do_req(1'b0, 2'b01, 16'h0000, 16'hABCD, 3, "load_restore");
    chk("load_restore_ar", 32'(ar), 32'h0200);
    last_word = 16'hABCD;
    do_req(1'b1, 2'b01, 16'h0000, 16'hABCD, 3, "load_norestore");
    chk("load_norestore_ar", 32'(ar1), 32'h0201);

    // Address wrap for fetch and push
    set_regs(16'hFFFF, 16'h0200, 16'h0000);
    poke(16'hFFFF, 8'h78);
    poke(16'h0000, 8'h56);
    do_req(1'b0, 2'b00, 16'h0000, 16'h5678, 3, "wrap_fetch");
    chk("wrap_fetch_pc", 32'(pc), 32'h0001);
    last_word = 16'h5678;
    do_req(1'b0, 2'b10, 16'h1122, last_word, 4, "wrap_push");
    chk("wrap_push_m_ffff", 32'(mem[16'hFFFF]), 32'h0011);
    chk("wrap_push_m_fffe", 32'(mem[16'hFFFE]), 32'h0022);
    chk("wrap_push_sp",     32'(sp),            32'hFFFE);

    // Handshake: request held high throughout one fetch
    @(negedge clk);
    set_regs(16'h0040, 16'h0200, 16'hFFFE);
    poke(16'h0040, 8'h88);
    poke(16'h0041, 8'h9A);
    exp_q.push_back(16'h9A88);
    if0.req_valid = 1'b1; if0.req_op = 2'b00; if0.wr_data = 16'h0000;
    chk("hs_ready_idle", 32'(if0.req_ready), 32'd1);
    not_ready = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!if0.req_ready) not_ready++;
      if (if0.resp_valid) begin
        pulses++;
        got = if0.resp_data;
      end
    end
    if0.req_valid = 1'b0;
    chk("hs_not_ready_cycles", 32'(not_ready), 32'd3);
    chk("hs_data", 32'(got), 32'(exp_q.pop_front()));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if0.resp_valid) pulses++;
    end
    chk("hs_single_resp", 32'(pulses), 32'd1);
    chk("hs_pc", 32'(pc), 32'h0042);

    // Reset during the first push write cycle
    set_regs(16'h0000, 16'h0200, 16'h0300);
    poke(16'h02FF, 8'h5A);
    if0.req_valid = 1'b1; if0.req_op = 2'b10; if0.wr_data = 16'hA1B2;
    @(negedge clk);
    if0.req_valid = 1'b0;
    chk("p0_regsel", 32'(regsel0), 32'b110);
    @(negedge clk);
    chk("p1_dout", 32'(dout0), 32'h00A1);
    chk("p1_wr",   32'(wr0),   32'd1);
    rst = 1'b1;
    #1;
    chk("rst_p1_cs", 32'(cs0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready",      32'(if0.req_ready),  32'd1);
    chk("abort_resp_valid", 32'(if0.resp_valid), 32'd0);
    chk("abort_cs",         32'(cs0),            32'd1);
    chk("abort_regsel",     32'(regsel0),        32'b111);
    chk("abort_sp",         32'(sp),             32'h02FF);
    chk("abort_mem",        32'(mem[16'h02FF]),  32'h005A);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if0.resp_valid) pulses++;
    end
    chk("abort_no_resp", 32'(pulses), 32'd0);
    chk("abort_resp_data", 32'(if0.resp_data), 32'h0000);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arf_access_sequencer.md
Name: arf_access_sequencer

Overview:
- Issuer-side controller for the AddressRegisterFile (PC, AR, SP). Drives its control inputs (FunSel, RegSel, OutDSel) and consumes its OutD output as the memory address.
- Performs 16-bit word transfers over the 8-bit data memory: instruction fetch via PC, data load via AR, stack push and pop via SP.
- Sits between the control unit (request/response handshake) and the ARF plus memory pair.

Parameters:
- RESTORE_AR, 1, when 1 LOAD_AR leaves AR unchanged at completion; when 0 AR ends at AR+1.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  1  request strobe.
- ReqOp  in  2  00 FETCH, 01 LOAD_AR, 10 PUSH, 11 POP.
- WrData  in  16  push data, sampled at acceptance.
- ReqReady  out  1  high only in IDLE.
- RespValid  out  1  one-cycle completion pulse.
- RespData  out  16  assembled read word.
- ARF_FunSel  out  3  000 Q-1, 001 Q+1 (other codes unused).
- ARF_RegSel  out  3  active-low enables: bit2 PC, bit1 AR, bit0 SP; 111 means none.
- ARF_OutDSel  out  2  00 PC, 10 AR, 11 SP.
- ARF_OutD  in  16  current address from the ARF; memory address bus.
- Mem_DataIn  in  8  combinational read data for address ARF_OutD.
- Mem_DataOut  out  8  write byte.
- Mem_CS  out  1  active-low chip select.
- Mem_WR  out  1  1 write, 0 read; memory writes on the rising edge when Mem_CS=0 and Mem_WR=1.

Behaviour:
- Word layout is little-endian: low byte at the lower address. The stack grows downward.
- Reset:
  - state goes to IDLE and RespData to 0.
  - RespValid=0, Mem_CS=1, Mem_WR=0, ARF_RegSel=111, ARF_FunSel=000, ARF_OutDSel=00, Mem_DataOut=0.
  - Reset mid-operation aborts immediately. No rollback: partially updated PC/AR/SP and memory bytes remain.
  - ARF contents are never cleared by this block.
- IDLE:
  - ReqReady=1, RegSel=111, Mem_CS=1.
  - ReqValid=1 at an edge accepts ReqOp and latches WrData into an internal register.
  - Next state is the first state of that op.
  - ReqValid while not in IDLE is ignored, since ReqReady=0.
- FETCH:
  - F0: OutDSel=00, CS=0, WR=0, FunSel=001, RegSel=011. Latch Mem_DataIn into RespData[7:0]; PC+1.
  - F1: same controls. Latch Mem_DataIn into RespData[15:8]; PC+1.
  - Then DONE.
- LOAD_AR:
  - A0: OutDSel=10, read low byte, FunSel=001, RegSel=101 (AR+1).
  - A1: read high byte. If RESTORE_AR=1: FunSel=000, RegSel=101 (AR-1). If RESTORE_AR=0: RegSel=111.
  - Then DONE.
- PUSH:
  - P0: RegSel=110, FunSel=000 (SP-1), CS=1.
  - P1: OutDSel=11, CS=0, WR=1, DataOut=WrData[15:8], SP-1.
  - P2: write WrData[7:0] at SP, RegSel=111.
  - Then DONE. Result: M[old-1]=high, M[old-2]=low, SP=old-2.
- POP:
  - R0: OutDSel=11, read low byte, SP+1.
  - R1: read high byte, SP+1.
  - Then DONE. SP ends at old+2.
- DONE:
  - RespValid=1 for exactly one cycle; RegSel=111, CS=1; next state IDLE.
  - For PUSH, RespData is unchanged (completion acknowledgement only).
- Latency from the accepting edge to the RespValid cycle:
  - FETCH, LOAD_AR, POP: 3 cycles.
  - PUSH: 4 cycles.
- Back-to-back issue: the next request can be accepted one cycle after DONE.
- Throughput: 1 word per 4 cycles for reads; 1 word per 5 cycles for PUSH.
- Address arithmetic wraps modulo 2^16 in the ARF; no checks are made here.
  - PC=FFFF fetches FFFF then 0000.
  - SP=0000 push writes FFFF then FFFE.
- Only one ARF register is enabled in any cycle. ARF_RegSel is never 111 during a state that expects an update.

Test Plan:
- FETCH: PC=0x0010, M[10]=0x34, M[11]=0x12 -> RespData=0x1234, RespValid 3 cycles after accept, PC=0x0012.
- PUSH then POP: SP=0x0100, WrData=0xBEEF -> M[FF]=0xBE, M[FE]=0xEF, SP=0x00FE. POP -> RespData=0xBEEF, SP=0x0100.
- LOAD_AR: AR=0x0200, M[200]=0xCD, M[201]=0xAB.
  - RESTORE_AR=1 -> RespData=0xABCD, AR=0x0200.
  - RESTORE_AR=0 -> AR=0x0201.
- Wrap: PC=0xFFFF, M[FFFF]=0x78, M[0000]=0x56 -> RespData=0x5678, PC=0x0001. SP=0x0000 PUSH 0x1122 -> M[FFFF]=0x11, M[FFFE]=0x22.
- Handshake: ReqValid held high continuously during FETCH -> no acceptance until IDLE, ReqReady low for 3 cycles, exactly one RespValid per accepted request.
- Reset in P1 of PUSH: assert Reset -> next cycle IDLE, RespValid=0, Mem_CS=1, RegSel=111; SP=old-1, M[old-1]=high byte written if the P1 edge completed.
